// File: rtl/edge_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_counter
//  Description : Counts rising edges of (sig & mask)[0] over a programmable
//                window and compares the total against an expected count.
//                Define EDGE_EVENT_COUNTER_SATURATE_EN to saturate the
//                counter instead of wrapping it.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_event_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int WIN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] expected,
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] mask,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] c_WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_expected;
    logic [WIN_W-1:0] r_remaining;
    logic             r_prev0;
    logic             r_ovf;
    logic             r_pass;

    logic [WIDTH-1:0] w_s;
    logic             w_s0;
    logic             w_edge;
    logic             w_at_max;
    logic             w_pass;
    logic             w_unused_hi;

    assign w_s      = sig & mask;
    assign w_s0     = w_s[0];
    // Upper bits are qualified but never act as edge sources.
    assign w_unused_hi = ^w_s;
    assign w_edge   = w_s0 & ~r_prev0;
    assign w_at_max = (r_count == {CNT_W{1'b1}});
    assign w_pass   = (r_count == r_expected) && !r_ovf;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_expected  <= '0;
            r_remaining <= '0;
            r_prev0     <= 1'b0;
            r_ovf       <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            // prev0 tracks s[0] in every state so boundary edges land correctly.
            r_prev0 <= w_s0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_pass      <= 1'b0;
                        r_expected  <= expected;
                        r_remaining <= window_len;
                        r_state     <= (window_len != '0) ? S_COUNT : S_DONE;
                    end
                end
                S_COUNT: begin
                    if (w_edge) begin
                        if (w_at_max) begin
                            r_ovf <= 1'b1;
`ifdef EDGE_EVENT_COUNTER_SATURATE_EN
                            r_count <= r_count;
`else
                            r_count <= '0;
`endif
                        end else begin
                            r_count <= r_count + c_CNT_ONE;
                        end
                    end
                    r_remaining <= r_remaining - c_WIN_ONE;
                    if (r_remaining == c_WIN_ONE) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_pass  <= w_pass;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign count    = r_count;
    assign busy     = (r_state == S_COUNT);
    assign done     = (r_state == S_DONE);
    // Result is visible during the done pulse and held afterwards.
    assign pass     = (r_state == S_DONE) ? w_pass : r_pass;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_event_counter
//  Description : Scoreboard bench for edge_event_counter; the stimulus side
//                queues expected window results, the monitor checks on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_counter;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] window_len;
    logic [3:0] expected;
    logic [3:0] sig;
    logic [3:0] mask;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       pass;
    logic       overflow;

    edge_event_counter #(.WIDTH(4), .CNT_W(4), .WIN_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .window_len (window_len),
        .expected   (expected),
        .sig        (sig),
        .mask       (mask),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .overflow   (overflow)
    );

    typedef struct {
        logic [3:0] cnt;
        logic       pas;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_count", int'(count), int'(e.cnt));
                check("done_pass", int'(pass), int'(e.pas));
                check("done_overflow", int'(overflow), int'(e.ovf));
                check("done_latency", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [7:0] wl, input logic [3:0] ex,
                         input logic [3:0] c, input logic p, input logic o);
        exp_t e;
        e.cnt = c;
        e.pas = p;
        e.ovf = o;
        e.cyc = cyc + 1 + int'(wl);
        sb.push_back(e);
        start      = 1'b1;
        window_len = wl;
        expected   = ex;
        tick();
        start      = 1'b0;
        window_len = 8'd0;
        expected   = 4'd0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        check(name, sb.size(), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; window_len = 8'd0; expected = 4'd0;
        sig = 4'd0; mask = 4'hF;
        tick(); tick();
        reset = 1'b0;
        @(negedge clock);
        check("reset_count", int'(count), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_pass", int'(pass), 0);
        check("reset_overflow", int'(overflow), 0);
        tick();

        // Values 0..10 on COUNT cycles 1..11: five rising edges on bit 0.
        issue(8'd11, 4'd5, 4'd5, 1'b1, 1'b0);
        for (int v = 0; v <= 10; v++) begin
            sig = v[3:0];
            if (v == 3) check("busy_in_window", int'(busy), 1);
            tick();
        end
        sig = 4'd0;
        drain("drain_bit0");
        tick();
        check("pass_held", int'(pass), 1);

        mask = 4'hE;
        issue(8'd11, 4'd5, 4'd0, 1'b0, 1'b0);
        for (int v = 0; v <= 10; v++) begin
            sig = v[3:0];
            tick();
        end
        sig = 4'd0;
        drain("drain_mask");
        mask = 4'hF;

`ifdef EDGE_EVENT_COUNTER_SATURATE_EN
        issue(8'd40, 4'd1, 4'd15, 1'b0, 1'b1);
`else
        issue(8'd40, 4'd1, 4'd1, 1'b0, 1'b1);
`endif
        for (int i = 0; i < 40; i++) begin
            sig = (i < 34 && (i % 2) == 0) ? 4'd1 : 4'd0;
            tick();
        end
        sig = 4'd0;
        drain("drain_wrap");

        issue(8'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        check("zero_win_busy", int'(busy), 0);
        drain("drain_zero");

        // Edge coincident with the accepted start must not be counted.
        tick();
        sig = 4'd1;
        issue(8'd3, 4'd0, 4'd0, 1'b1, 1'b0);
        tick(); tick(); tick();
        sig = 4'd0;
        drain("drain_start_edge");

        // A second start mid-window is ignored: three edges, ten cycles.
        issue(8'd10, 4'd3, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            sig = (i < 6 && (i % 2) == 0) ? 4'd1 : 4'd0;
            if (i == 3) begin
                start = 1'b1; window_len = 8'd2; expected = 4'd0;
            end else begin
                start = 1'b0; window_len = 8'd0;
            end
            tick();
        end
        start = 1'b0;
        sig = 4'd0;
        drain("drain_ignore");

        // Reset mid-window: aborted, no done pulse may follow.
        start = 1'b1; window_len = 8'd10; expected = 4'd2;
        tick();
        start = 1'b0;
        sig = 4'd1; tick();
        sig = 4'd0; tick();
        sig = 4'd1; tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sig = 4'd0;
        check("abort_busy", int'(busy), 0);
        check("abort_count", int'(count), 0);
        check("abort_pass", int'(pass), 0);
        check("abort_done", int'(done), 0);
        for (int i = 0; i < 15; i++) begin
            sig = {3'b0, i[0]};
            tick();
        end
        check("abort_queue", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_event_counter.md
EDGE_EVENT_COUNTER -- requirements
Module: edge_event_counter

Interface
REQ-001 Parameter: WIDTH, default 4, width of the sampled signal vector.
REQ-002 Parameter: CNT_W, default 4, width of the edge counter and the expected-count compare.
REQ-003 Parameter: WIN_W, default 8, width of the window-length field.
REQ-004 Port: clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: start  in  1  pulse; opens a counting window when the block is idle.
REQ-007 Port: window_len  in  WIN_W  window length in clock cycles, sampled on an accepted start.
REQ-008 Port: expected  in  CNT_W  expected edge count, sampled on an accepted start.
REQ-009 Port: sig  in  WIDTH  monitored vector.
REQ-010 Port: mask  in  WIDTH  qualifier; the block samples s = sig & mask.
REQ-011 Port: count  out  CNT_W  edges counted in the current or last window.
REQ-012 Port: busy  out  1  high while a window is open.
REQ-013 Port: done  out  1  one-cycle pulse when a window closes.
REQ-014 Port: pass  out  1  result of the last window; held until the next accepted start.
REQ-015 Port: overflow  out  1  sticky per window; counter exceeded 2^CNT_W-1.

Function
REQ-016 Edge rule: an edge is s[0]==1 while prev0==0, where prev0 is s[0] registered every cycle; bits [WIDTH-1:1] are never edge sources.
REQ-017 The FSM has three states: IDLE, COUNT and DONE.
REQ-018 IDLE with start=1 and window_len>0: latch window_len and expected, clear count and overflow, clear pass, then go to COUNT.
REQ-019 IDLE with start=1 and window_len==0: clear count and overflow, then go to DONE; no cycle is counted.
REQ-020 COUNT: busy=1; each cycle, count increments by 1 on an edge and the remaining-cycle counter decrements; after exactly window_len COUNT cycles, go to DONE.
REQ-021 An edge present in the same cycle that start is accepted is not counted.
REQ-022 DONE: done=1 for that single cycle; pass = (count==expected) && !overflow; return to IDLE next cycle.
REQ-023 start while in COUNT or DONE is ignored; latched window_len and expected are unchanged.
REQ-024 Counter wrap: count increments modulo 2^CNT_W; an increment from all-ones sets overflow.
REQ-025 Latency: done asserts window_len+1 cycles after the start cycle (1 cycle when window_len==0).
REQ-026 prev0 updates in every state, so an edge straddling the window boundary is attributed to the cycle in which s[0] first reads 1.

Reset
REQ-027 With reset=1 at a clock edge, the FSM goes to IDLE and count=0, busy=0, done=0, pass=0, overflow=0, prev0=0, remaining=0.
REQ-028 Reset mid-window aborts the window with no done pulse; reset has priority over start.

Configuration
REQ-029 Macro EDGE_EVENT_COUNTER_SATURATE_EN: when defined, count saturates at 2^CNT_W-1 instead of wrapping, and overflow still sets on the first saturated edge.
REQ-030 Without EDGE_EVENT_COUNTER_SATURATE_EN: count wraps per REQ-024.

Verification
REQ-031 Bit-0 count: mask=4'hF, window_len=11, expected=5; sig=0 before start, then 0..10 on COUNT cycles 1..11 -> count=5, pass=1, done 12 cycles after start.
REQ-032 Mask blocks bit 0: same stimulus with mask=4'hE -> count=0, pass=0, overflow=0.
REQ-033 Wrap: CNT_W=4, 17 edges in a 40-cycle window, expected=1 -> count=1, overflow=1, pass=0; with the macro defined -> count=15, overflow=1.
REQ-034 Zero window: start with window_len=0, expected=0 -> done in the next cycle, busy never 1, count=0, pass=1.
REQ-035 Abort/ignore: start again mid-window -> no effect; reset mid-window -> busy=0, count=0, no done, pass=0.
